// File: rtl/full_adder.sv
// Single-bit full adder: combinational sum/carry plus a registered side that can
// also accumulate a WIDTH-bit word serially with carry feedback.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             carry,
  input  logic             valid_in,
  input  logic             serial_mode,
  input  logic             start,
  output logic             sum_q,
  output logic             carry_q,
  output logic             valid_q,
  output logic [WIDTH-1:0] word_q,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic             cin_eff;
  logic             sum_d, carry_d, valid_d, word_done_d, word_done_q;
  logic             carry_fb_d, carry_fb_q, mode_d, mode_q;
  logic [WIDTH-1:0] word_d;
  logic [CW-1:0]    cnt_d, cnt_q, cnt_base, cnt_inc;

  // Zero-latency adder; serial mode chains the previous beat's carry unless start.
  always_comb begin
    cin_eff = (serial_mode && !start) ? carry_fb_q : cin;
    sum     = a ^ b ^ cin_eff;
    carry   = (a & b) | (a & cin_eff) | (b & cin_eff);
  end

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_fb_d  = carry_fb_q;
    word_d      = word_q;
    valid_d     = valid_in;
    word_done_d = 1'b0;
    mode_d      = serial_mode;
    // A mode change abandons any partial word; the shift register keeps its bits.
    cnt_base    = (serial_mode != mode_q) ? '0 : cnt_q;
    cnt_d       = cnt_base;
    cnt_inc     = start ? CW'(1) : cnt_base + CW'(1);
    if (valid_in) begin
      sum_d   = sum;
      carry_d = carry;
      if (serial_mode) begin
        carry_fb_d = carry;
        word_d     = {sum, word_q[WIDTH-1:1]};
        if (cnt_inc == CNT_MAX) begin
          cnt_d       = '0;
          word_done_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 1'b0;
      carry_q     <= 1'b0;
      valid_q     <= 1'b0;
      word_q      <= '0;
      word_done_q <= 1'b0;
      carry_fb_q  <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
      word_q      <= word_d;
      word_done_q <= word_done_d;
      carry_fb_q  <= carry_fb_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign word_done = word_done_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: truth table, registered path, reset and
// serial words, with per-beat expectations queued on drive and popped on sample.
module tb_full_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, a, b, cin, valid_in, serial_mode, start;
  logic         sum, carry, sum_q, carry_q, valid_q, word_done;
  logic [W-1:0] word_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        tag;
    logic         s, c, v, wd;
    logic [W-1:0] w;
    bit           chk_sc, chk_w;
  } exp_t;

  exp_t sb[$];

  full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
    .valid_in(valid_in), .serial_mode(serial_mode), .start(start),
    .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q), .word_q(word_q),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic s, c, v, wd,
                              input logic [W-1:0] w, input bit chk_sc, chk_w);
    exp_t e;
    e.tag = tag; e.s = s; e.c = c; e.v = v; e.wd = wd; e.w = w;
    e.chk_sc = chk_sc; e.chk_w = chk_w;
    return e;
  endfunction

  // Drive one clock's worth of inputs, queue its expectation, sample after the edge.
  task automatic beat(input logic ai, bi, ci, vi, mi, si, ri, input exp_t e);
    exp_t got;
    @(negedge clk);
    a = ai; b = bi; cin = ci; valid_in = vi; serial_mode = mi; start = si; rst = ri;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_eq({e.tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      if (got.chk_sc) begin
        check_eq({got.tag, "_sum_q"}, sum_q, got.s);
        check_eq({got.tag, "_carry_q"}, carry_q, got.c);
      end
      check_eq({got.tag, "_valid_q"}, valid_q, got.v);
      check_eq({got.tag, "_word_done"}, word_done, got.wd);
      if (got.chk_w) check_eq({got.tag, "_word_q"}, word_q, got.w);
    end
  endtask

  // Serial add of bits [first, last] of A+B; bit 'first'==0 carries start.
  task automatic serial_bits(input string tag, input logic [W-1:0] av, bv,
                             input logic ci, input int first, input int last);
    logic [W:0] part, full;
    logic [W:0] m;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    for (int i = first; i <= last; i++) begin
      m    = (W+1)'((1 << (i + 1)) - 1);
      part = ({1'b0, av} & m) + ({1'b0, bv} & m) + {{W{1'b0}}, ci};
      beat(av[i], bv[i], ci, 1'b1, 1'b1, (i == 0), 1'b0,
           mk($sformatf("%s_b%0d", tag, i), part[i], part[i+1], 1'b1, (i == W-1),
              full[W-1:0], 1'b1, (i == W-1)));
    end
  endtask

  initial begin
    logic [2:0] tt_in  [7];
    logic [1:0] tt_out [7];
    tt_in  = '{3'b100, 3'b001, 3'b011, 3'b101, 3'b010, 3'b111, 3'b000};
    tt_out = '{2'b10,  2'b10,  2'b01,  2'b01,  2'b10,  2'b11,  2'b00};
    rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0;
    valid_in = 1'b0; serial_mode = 1'b0; start = 1'b0;

    // Combinational truth table, no clock dependence.
    for (int i = 0; i < 7; i++) begin
      {a, b, cin} = tt_in[i];
      #1;
      check_eq($sformatf("comb%0d_sum", i), sum, tt_out[i][1]);
      check_eq($sformatf("comb%0d_carry", i), carry, tt_out[i][0]);
    end

    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk("reset", 0, 0, 0, 0, '0, 1, 1));

    // Parallel path: capture, then hold with valid dropped.
    beat(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk("par_cap", 0, 1, 1, 0, '0, 1, 0));
    beat(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk("par_hold", 0, 1, 0, 0, '0, 1, 0));

    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk("rst_prio", 0, 0, 0, 0, '0, 1, 1));

    serial_bits("s5a3c", 8'h5A, 8'h3C, 1'b0, 0, W-1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk("s5a3c_idle", 1, 0, 0, 0, 8'h96, 1, 1));

    serial_bits("sff01", 8'hFF, 8'h01, 1'b0, 0, W-1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk("sff01_idle", 0, 1, 0, 0, 8'h00, 1, 1));
    serial_bits("s0101", 8'h01, 8'h01, 1'b0, 0, W-1);

    // Reset at bit 4 of a word; counter must restart so 4 extra beats don't finish it.
    serial_bits("s1020a", 8'h10, 8'h20, 1'b0, 0, 3);
    beat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, mk("mid_rst", 0, 0, 0, 0, '0, 1, 1));
    for (int i = 0; i < 4; i++)
      beat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
           mk($sformatf("post_rst%0d", i), 0, 0, 1, 0, '0, 0, 0));
    serial_bits("s1020", 8'h10, 8'h20, 1'b0, 0, W-1);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk("s1020_idle", 0, 0, 0, 0, 8'h30, 1, 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
# full_adder

Single-bit full adder with a combinational sum/carry path and a registered, clocked side. The registered side can also run as a bit-serial adder, where the carry is fed back from one cycle to the next. The block is the leaf arithmetic cell for ripple and serial adders in the datapath. The combinational outputs are used directly by any parent that needs zero-latency addition. The registered outputs serve pipelined or serial users.

## Interface
Parameters:
- WIDTH, default 8: length of the serial result shift register and the serial word length.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- a  input  1  addend bit.
- b  input  1  addend bit.
- cin  input  1  carry-in bit.
- sum  output  1  combinational sum, a ^ b ^ cin_eff.
- carry  output  1  combinational carry-out, majority(a, b, cin_eff).
- valid_in  input  1  qualifies a, b and cin for the registered path.
- serial_mode  input  1  0 = parallel/pipelined; 1 = bit-serial with carry feedback.
- start  input  1  serial mode only; marks the LSB of a new word, so cin is used instead of the fed-back carry.
- sum_q  output  1  registered sum.
- carry_q  output  1  registered carry.
- valid_q  output  1  registered valid_in.
- word_q  output  WIDTH  serial result; sum bits shifted in LSB-first.
- word_done  output  1  one-cycle pulse when WIDTH serial bits have been accumulated.

## Operation
- cin_eff selects the carry-in:
  - serial_mode=0: cin_eff = cin.
  - serial_mode=1 and start=1: cin_eff = cin.
  - serial_mode=1 and start=0: cin_eff = carry_fb, the carry register.
- sum = a ^ b ^ cin_eff.
- carry = (a & b) | (a & cin_eff) | (b & cin_eff).
- sum and carry are purely combinational, with no dependence on clk except through carry_fb in serial mode.
- Parallel mode:
  - On valid_in=1, capture sum_q, carry_q and valid_q=1.
  - On valid_in=0, valid_q=0 and sum_q/carry_q hold.
- Serial mode, on each valid_in=1 beat:
  - carry_fb <= carry.
  - word_q <= {sum, word_q[WIDTH-1:1]}, i.e. right shift so that after WIDTH beats bit 0 holds the LSB.
  - The bit counter increments.
- start=1 with valid_in=1 clears the bit counter to 1; that beat counts as bit 0.
- When the counter reaches WIDTH, word_done pulses high for one cycle and the counter returns to 0.
- The final carry stays in carry_fb and carry_q.
- valid_in=0: no state change except valid_q <= 0 and word_done <= 0.
- Toggling serial_mode mid-word aborts the word:
  - The counter clears.
  - word_q is kept.
  - word_done is not asserted.

## Timing
- Combinational outputs settle within the same delta/time step as the inputs; zero cycles of latency.
- Registered outputs have 1-cycle latency from the valid_in edge.
- word_done is asserted in the cycle after the WIDTH-th valid beat is sampled.
- Reset, sampled on a rising clk edge with rst=1, clears all state to 0: sum_q, carry_q, valid_q, word_q, word_done, carry_fb and the counter.
- rst has priority over valid_in and start.
- Reset mid-word discards the partial word; the next word needs start.
- Outputs before the first clk edge are undefined only for registered signals; the combinational outputs are always valid.

## Test plan
- Combinational truth table, checked 1 time unit after each apply with no clock:
  - a,b,cin=1,0,0 -> sum=1, carry=0.
  - 0,0,1 -> sum=1, carry=0.
  - 0,1,1 -> sum=0, carry=1.
  - 1,0,1 -> sum=0, carry=1.
  - 0,1,0 -> sum=1, carry=0.
  - 1,1,1 -> sum=1, carry=1.
  - 0,0,0 -> sum=0, carry=0.
- Parallel registered path: apply a=1, b=1, cin=0 with valid_in=1 -> after 1 clk, sum_q=0, carry_q=1, valid_q=1. Then drop valid_in -> valid_q=0 and the values hold.
- Reset priority: assert rst together with valid_in=1 -> every registered output and word_q is 0 after the edge.
- Serial add, WIDTH=8: A=0x5A, B=0x3C, cin=0, LSB-first, start on bit 0 -> word_done pulses once, word_q=0x96, carry_q=0.
- Serial add with overflow: A=0xFF, B=0x01 -> word_q=0x00, carry_q=1. Then start a new word with A=0x01, B=0x01, cin=0 -> word_q=0x02; the old carry must not leak in.
- Reset at bit 4 of a serial word -> counter clears and no word_done. A following full word A=0x10, B=0x20 gives word_q=0x30.
